// File: rtl/dma_pcis_wrstrb_merge_if.sv
// Beat-in / line-out bus of the PCIS write-strobe merge stage.
// The slave modport is the merge block; the master modport is the source and sink.
interface dma_pcis_wrstrb_merge_if #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 64
);
    localparam int NLANES = DATA_W / 8;

    logic [DATA_W-1:0] packet_in;
    logic [NLANES-1:0] wrstrb_in;
    logic [ADDR_W-1:0] addr_in;
    logic              last_in;
    logic              packet_in_valid;
    logic              packet_in_grant;
    logic [DATA_W-1:0] packet_out;
    logic [NLANES-1:0] wrstrb_out;
    logic [ADDR_W-1:0] addr_out;
    logic              packet_out_valid;
    logic              packet_out_grant;

    modport slave (
        input  packet_in, wrstrb_in, addr_in, last_in, packet_in_valid, packet_out_grant,
        output packet_in_grant, packet_out, wrstrb_out, addr_out, packet_out_valid
    );

    modport master (
        output packet_in, wrstrb_in, addr_in, last_in, packet_in_valid, packet_out_grant,
        input  packet_in_grant, packet_out, wrstrb_out, addr_out, packet_out_valid
    );
endinterface

// File: rtl/dma_pcis_wrstrb_merge.sv
// Merges sparse-strobe DMA write beats to one line address into a single line,
// flushing on full strobe, last, address change, beat limit or idle timeout.
module dma_pcis_wrstrb_merge #(
    parameter int DATA_W    = 512,
    parameter int ADDR_W    = 64,
    parameter int MAX_BEATS = 16,
    parameter int TIMEOUT   = 32
) (
    input  logic clk,
    input  logic rst,
    dma_pcis_wrstrb_merge_if.slave bus
);
    localparam int NLANES = DATA_W / 8;
    localparam int BCW    = $clog2(MAX_BEATS + 1);
    localparam int ICW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(MAX_BEATS - 1);
    localparam logic [ICW-1:0] IDLE_LAST = ICW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] acc_data, base_data, merged_data;
    logic [NLANES-1:0] acc_strb, merged_strb;
    logic [ADDR_W-1:0] acc_addr;
    logic [BCW-1:0]    beat_cnt;
    logic [ICW-1:0]    idle_cnt;
    logic              in_grant, accept, addr_hit;

    // In IDLE the accumulator is merged against zero so unstrobed lanes come out 0.
    always_comb begin
        base_data   = (state == IDLE) ? '0 : acc_data;
        merged_strb = ((state == IDLE) ? '0 : acc_strb) | bus.wrstrb_in;
        merged_data = base_data;
        for (int i = 0; i < NLANES; i++)
            if (bus.wrstrb_in[i]) merged_data[8*i +: 8] = bus.packet_in[8*i +: 8];
    end

    assign addr_hit = (bus.addr_in == acc_addr);
    assign accept   = bus.packet_in_valid && in_grant;

    always_comb begin
        state_nx = state;
        in_grant = 1'b0;
        case (state)
            IDLE: begin
                in_grant = !rst;
                if (accept)
                    state_nx = (&bus.wrstrb_in || bus.last_in || MAX_BEATS == 1) ? OUT : ACCUM;
            end
            ACCUM: begin
                in_grant = !rst && !(bus.packet_in_valid && !addr_hit);
                if (bus.packet_in_valid) begin
                    // A mismatched address closes the line; the beat is re-presented later.
                    if (!addr_hit || &merged_strb || bus.last_in || beat_cnt == BEAT_LAST)
                        state_nx = OUT;
                end else if (TIMEOUT != 0 && idle_cnt == IDLE_LAST) begin
                    state_nx = OUT;
                end
            end
            OUT: begin
                if (bus.packet_out_grant) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc_data <= '0;
            acc_strb <= '0;
            acc_addr <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (accept) begin
                    acc_data <= merged_data;
                    acc_strb <= merged_strb;
                    acc_addr <= bus.addr_in;
                    beat_cnt <= BCW'(1);
                    idle_cnt <= '0;
                end
                ACCUM: begin
                    if (accept) begin
                        acc_data <= merged_data;
                        acc_strb <= merged_strb;
                        beat_cnt <= beat_cnt + BCW'(1);
                        idle_cnt <= '0;
                    end else if (!bus.packet_in_valid) begin
                        idle_cnt <= idle_cnt + ICW'(1);
                    end
                end
                OUT: if (bus.packet_out_grant) begin
                    acc_data <= '0;
                    acc_strb <= '0;
                    beat_cnt <= '0;
                    idle_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.packet_in_grant  = in_grant;
    assign bus.packet_out_valid = (state == OUT);
    assign bus.packet_out       = (state == OUT) ? acc_data : '0;
    assign bus.wrstrb_out       = (state == OUT) ? acc_strb : '0;
    assign bus.addr_out         = (state == OUT) ? acc_addr : '0;
endmodule

// File: tb/tb_dma_pcis_wrstrb_merge.sv
// Directed bench for the write-strobe merge stage: split/overlap lines, address change,
// timeout vs last, backpressure, beat limit and async reset.
module tb_dma_pcis_wrstrb_merge;
    localparam int DATA_W = 512;
    localparam int ADDR_W = 64;
    localparam int NL     = DATA_W / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ncmp = 0;
    int   nerr = 0;
    int   nxfer = 0;

    always #5 clk = ~clk;

    dma_pcis_wrstrb_merge_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) b ();

    dma_pcis_wrstrb_merge #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BEATS(16), .TIMEOUT(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    always @(posedge clk) if (b.packet_out_valid && b.packet_out_grant) nxfer++;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [DATA_W-1:0] d, input logic [NL-1:0] s,
                         input logic [ADDR_W-1:0] a, input logic l);
        b.packet_in = d; b.wrstrb_in = s; b.addr_in = a; b.last_in = l;
        b.packet_in_valid = 1'b1;
    endtask

    task automatic nodrive();
        b.packet_in_valid = 1'b0;
        b.last_in = 1'b0;
    endtask

    task automatic take();
        b.packet_out_grant = 1'b1;
        tick();
        b.packet_out_grant = 1'b0;
    endtask

    // Counts negedges after an accept edge until valid is seen (bounded).
    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!b.packet_out_valid && cyc < 40);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] exp_d;
        logic [7:0]        byte_v;
        int                cyc, seen, x0, bad;

        b.packet_in = '0; b.wrstrb_in = '0; b.addr_in = '0; b.last_in = 1'b0;
        b.packet_in_valid = 1'b0; b.packet_out_grant = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_grant", b.packet_in_grant, 0);
        chk("rst_valid", b.packet_out_valid, 0);
        chk("rst_data", b.packet_out, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_grant", b.packet_in_grant, 1);

        // split line
        tick();
        drive({64{8'h11}}, {{32{1'b1}}, {32{1'b0}}}, 64'h1000, 1'b0);
        @(negedge clk);
        chk("split_grantA", b.packet_in_grant, 1);
        tick();
        drive({64{8'h22}}, {{32{1'b0}}, {32{1'b1}}}, 64'h1000, 1'b0);
        @(negedge clk);
        chk("split_grantB", b.packet_in_grant, 1);
        chk("split_novalid", b.packet_out_valid, 0);
        tick();
        nodrive();
        @(negedge clk);
        chk("split_valid", b.packet_out_valid, 1);
        chk("split_strb", b.wrstrb_out, {NL{1'b1}});
        chk("split_data", b.packet_out, {{32{8'h11}}, {32{8'h22}}});
        chk("split_addr", b.addr_out, 64'h1000);
        take();
        @(negedge clk);
        chk("split_done", b.packet_out_valid, 0);
        chk("bubble_grant", b.packet_in_grant, 1);

        // overlap: last write wins
        tick();
        drive({64{8'hAA}}, 64'h1, 64'h40, 1'b0);
        tick();
        drive({{63{8'h33}}, 8'hBB}, {NL{1'b1}}, 64'h40, 1'b0);
        tick();
        nodrive();
        @(negedge clk);
        chk("ovl_data", b.packet_out, {{63{8'h33}}, 8'hBB});
        chk("ovl_strb", b.wrstrb_out, {NL{1'b1}});
        take();

        // address change
        drive({64{8'h5A}}, 64'hF, 64'h1000, 1'b0);
        tick();
        drive({64{8'h77}}, 64'hF0, 64'h2000, 1'b1);
        @(negedge clk);
        chk("addr_grant0", b.packet_in_grant, 0);
        tick();
        @(negedge clk);
        chk("addr_valid", b.packet_out_valid, 1);
        chk("addr_strb", b.wrstrb_out, 64'hF);
        chk("addr_data", b.packet_out, {{60{8'h00}}, 32'h5A5A5A5A});
        chk("addr_addr", b.addr_out, 64'h1000);
        chk("addr_outgrant", b.packet_in_grant, 0);
        take();
        @(negedge clk);
        chk("addr_idle_grant", b.packet_in_grant, 1);
        tick();
        nodrive();
        @(negedge clk);
        chk("addr2_addr", b.addr_out, 64'h2000);
        chk("addr2_data", b.packet_out, {{56{8'h00}}, 32'h77777777, 32'h0});
        take();

        // single partial beat times out
        drive({64{8'h10}}, 64'h3, 64'h3000, 1'b0);
        tick();
        nodrive();
        wait_valid(cyc);
        chk("timeout_cyc", cyc, 17);
        chk("timeout_strb", b.wrstrb_out, 64'h3);
        take();

        // same with last: immediate
        drive({64{8'h10}}, 64'h3, 64'h3000, 1'b1);
        tick();
        nodrive();
        wait_valid(cyc);
        chk("last_cyc", cyc, 1);
        take();

        // beat arriving on the timeout cycle wins and restarts the count
        drive({64{8'h10}}, 64'h3, 64'h3000, 1'b0);
        tick();
        nodrive();
        repeat (15) @(posedge clk);
        #1;
        drive({64{8'h20}}, 64'hC, 64'h3000, 1'b0);
        @(negedge clk);
        chk("race_novalid", b.packet_out_valid, 0);
        tick();
        nodrive();
        wait_valid(cyc);
        chk("race_cyc", cyc, 17);
        chk("race_data", b.packet_out, {{60{8'h00}}, 32'h20201010});
        take();

        // backpressure
        drive({64{8'hC3}}, {NL{1'b1}}, 64'h5000, 1'b0);
        tick();
        nodrive();
        x0 = nxfer;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (b.packet_out !== {64{8'hC3}} || b.wrstrb_out !== {NL{1'b1}} ||
                b.addr_out !== 64'h5000 || b.packet_in_grant !== 1'b0 || b.packet_out_valid !== 1'b1)
                bad++;
        end
        chk("bp_stable", bad, 0);
        take();
        @(negedge clk);
        chk("bp_xfer", nxfer - x0, 1);
        chk("bp_done", b.packet_out_valid, 0);

        // beat limit: 16 single-lane beats
        exp_d = '0;
        for (int i = 0; i < 16; i++) begin
            byte_v = 8'(i + 1);
            exp_d[8*i +: 8] = byte_v;
            drive({64{byte_v}}, 64'h1 << i, 64'h7000, 1'b0);
            if (i == 15) begin
                @(negedge clk);
                chk("lim_novalid", b.packet_out_valid, 0);
            end
            tick();
        end
        nodrive();
        @(negedge clk);
        chk("lim_valid", b.packet_out_valid, 1);
        chk("lim_strb", b.wrstrb_out, 64'hFFFF);
        chk("lim_data", b.packet_out, exp_d);
        take();

        // async reset mid-ACCUM
        drive({64{8'h01}}, 64'h1, 64'h8000, 1'b0); tick();
        drive({64{8'h02}}, 64'h2, 64'h8000, 1'b0); tick();
        drive({64{8'h04}}, 64'h4, 64'h8000, 1'b0); tick();
        nodrive();
        #2 rst = 1'b1;
        #1;
        chk("arst_acc_grant", b.packet_in_grant, 0);
        chk("arst_acc_valid", b.packet_out_valid, 0);
        tick();
        rst = 1'b0;
        x0 = nxfer;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (b.packet_out_valid) seen++;
        end
        chk("arst_acc_noout", seen, 0);

        // async reset mid-OUT
        tick();
        drive({64{8'hE7}}, {NL{1'b1}}, 64'h9000, 1'b0);
        tick();
        nodrive();
        @(negedge clk);
        chk("arst_out_pre", b.packet_out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", b.packet_out_valid, 0);
        chk("arst_out_data", b.packet_out, 0);
        chk("arst_out_strb", b.wrstrb_out, 0);
        chk("arst_out_addr", b.addr_out, 0);
        tick();
        rst = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (b.packet_out_valid) seen++;
        end
        chk("arst_out_noout", seen, 0);
        chk("arst_noxfer", nxfer - x0, 0);
        chk("arst_grant", b.packet_in_grant, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
